tcb_lib_arbiter_rr: RTL

- Round-robin arbiter with burst limit and lock support for sharing one TCB subordinate among IFN managers.
- Drives the `sel` input of `tcb_lib_multiplexer`, alongside or in place of the fixed-priority `tcb_lib_arbiter`.
- Provides a second, response-aligned select delayed by the handshake response latency DLY, so the read-data/status return path is steered to the originating manager.
- Arbitration is zero-latency: a request can be granted in the cycle it appears.

---
 rtl/tcb_lib_arbiter_rr_pkg.sv | 27 ++
 rtl/tcb_lib_arbiter_search.sv | 28 ++
 rtl/tcb_lib_arbiter_rr.sv | 108 ++++++++++
 3 files changed

// File: rtl/tcb_lib_arbiter_rr_pkg.sv
// Shared types and defaults for the TCB arbiters.
// Holds the arbitration-mode enum, FSM states and burst/handshake defaults.
package tcb_lib_arbiter_rr_pkg;

    typedef enum logic {
        FIXED,
        RR
    } tcb_arb_md_t;

    typedef enum logic {
        ARB,
        OWN
    } tcb_arb_st_t;

    typedef struct packed {
        logic [31:0] DLY;
    } tcb_hsk_cfg_t;

    localparam tcb_hsk_cfg_t TCB_HSK_DEF     = '{DLY: 32'd1};
    localparam int           TCB_ARB_BRN_DEF = 1;

    // Burst counter saturates instead of wrapping during long locked sequences.
    function automatic logic [7:0] cnt_inc(input logic [7:0] c);
        return (c == 8'hFF) ? c : c + 8'd1;
    endfunction

endpackage

// File: rtl/tcb_lib_arbiter_search.sv
// Rotating-priority encoder: first set vld bit at or after ptr, wrapping mod IFN.
// Purely combinational.
module tcb_lib_arbiter_search #(
    parameter int IFN = 3,
    parameter int IFL = $clog2(IFN)
)(
    input  logic [IFN-1:0] vld,
    input  logic [IFL-1:0] ptr,
    output logic [IFL-1:0] idx,
    output logic           any
);

    always_comb begin
        int j;
        j   = 0;
        idx = '0;
        any = 1'b0;
        for (int k = 0; k < IFN; k++) begin
            j = int'(ptr) + k;
            if (j >= IFN) j = j - IFN;
            if (!any && vld[j]) begin
                any = 1'b1;
                idx = IFL'(j);
            end
        end
    end

endmodule

// File: rtl/tcb_lib_arbiter_rr.sv
// Round-robin TCB arbiter with burst limit, lock and response-aligned select.
// Zero-latency grant; a stalled grant holds sel until the transfer completes.
module tcb_lib_arbiter_rr
    import tcb_lib_arbiter_rr_pkg::*;
#(
    parameter int IFN = 3,
    parameter int IFL = $clog2(IFN),
    parameter int DLY = int'(TCB_HSK_DEF.DLY),
    parameter int BRN = TCB_ARB_BRN_DEF
)(
    input  logic           clk,
    input  logic           rst,
    input  logic [IFN-1:0] vld,
    input  logic [IFN-1:0] lck,
    input  logic           rdy,
    output logic [IFL-1:0] sel,
    output logic [IFN-1:0] gnt,
    output logic [IFL-1:0] rsp_sel,
    output logic           bsy
);

    tcb_arb_st_t    state;
    logic [IFL-1:0] own;
    logic [IFL-1:0] ptr;
    logic [7:0]     cnt;
    logic [IFL-1:0] win;
    logic           any;
    logic [IFL-1:0] ptr_nxt;
    logic           others;
    logic           brn_hit;

    tcb_lib_arbiter_search #(
        .IFN (IFN),
        .IFL (IFL)
    ) u_search (
        .vld (vld),
        .ptr (ptr),
        .idx (win),
        .any (any)
    );

    always_comb begin
        sel = own;
        gnt = '0;
        bsy = 1'b1;
        if (state == ARB) begin
            bsy = any & ~rdy;
            if (any) begin
                sel = win;
                gnt = IFN'(1) << win;
            end
        end else if (vld[own]) begin
            gnt = IFN'(1) << own;
        end
    end

    assign ptr_nxt = (sel == IFL'(IFN-1)) ? '0 : sel + 1'b1;
    assign others  = |(vld & ~(IFN'(1) << own));
    assign brn_hit = ({1'b0, cnt} + 9'd1) >= 9'(BRN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ARB;
            own   <= '0;
            ptr   <= '0;
            cnt   <= '0;
        end else if (state == ARB) begin
            if (any) begin
                own <= win;
                if (rdy) begin
                    cnt   <= 8'd1;
                    ptr   <= ptr_nxt;
                    state <= (lck[win] || BRN > 1) ? OWN : ARB;
                end else begin
                    // Stalled grant: freeze sel, first real transfer counts as 1.
                    cnt   <= '0;
                    state <= OWN;
                end
            end
        end else begin
            if (!vld[own]) begin
                state <= ARB;
            end else if (rdy) begin
                cnt <= cnt_inc(cnt);
                ptr <= ptr_nxt;
                if (!lck[own] && (brn_hit || !others)) state <= ARB;
            end
        end
    end

    generate
        if (DLY == 0) begin : g_rsp_comb
            assign rsp_sel = sel;
        end else begin : g_rsp_reg
            logic [IFL-1:0] rsp [DLY];
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int k = 0; k < DLY; k++) rsp[k] <= '0;
                end else begin
                    rsp[0] <= sel;
                    for (int k = 1; k < DLY; k++) rsp[k] <= rsp[k-1];
                end
            end
            assign rsp_sel = rsp[DLY-1];
        end
    endgenerate

endmodule
